// File: rtl/pq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pq_pkg
// Key-value type and sentinel constants shared with the priority queue.
// Rev 1.0
// ----------------------------------------------------------------------------
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam logic [KEY_W-1:0] KEYINF = {KEY_W{1'b1}};
  localparam logic [VAL_W-1:0] VAL0   = {VAL_W{1'b0}};
endpackage
`default_nettype wire

// File: rtl/pq_stream_adapter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pq_stream_adapter_if
// Command stream, result stream and priority-queue side of the adapter.
// Rev 1.0
// ----------------------------------------------------------------------------
interface pq_stream_adapter_if;
  import pq_pkg::*;

  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_op;
  kv_t         s_kv;
  logic        m_valid;
  logic        m_ready;
  kv_t         m_kv;
  logic        m_err;
  logic        pq_enq;
  logic        pq_deq;
  kv_t         pq_kvi;
  kv_t         pq_kvo;
  logic        pq_full;
  logic        pq_empty;
  logic        pq_busy;
  logic [15:0] drop_cnt;

  modport slave (
    input  s_valid, s_op, s_kv, m_ready, pq_kvo, pq_full, pq_empty, pq_busy,
    output s_ready, m_valid, m_kv, m_err, pq_enq, pq_deq, pq_kvi, drop_cnt
  );

  modport master (
    output s_valid, s_op, s_kv, m_ready, pq_kvo, pq_full, pq_empty, pq_busy,
    input  s_ready, m_valid, m_kv, m_err, pq_enq, pq_deq, pq_kvi, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pq_stream_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pq_stream_adapter
// Serialises a valid/ready command stream onto a priority queue, returning results.
// Rev 1.0
// ----------------------------------------------------------------------------
module pq_stream_adapter
  import pq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  pq_stream_adapter_if.slave bus
);

  localparam int c_caw = $clog2(CMD_DEPTH);
  localparam int c_raw = $clog2(RES_DEPTH);

  localparam logic [c_caw:0]   c_cmd_full    = (c_caw+1)'(CMD_DEPTH);
  localparam logic [c_raw:0]   c_res_full    = (c_raw+1)'(RES_DEPTH);
  localparam logic [c_caw-1:0] c_cmd_ptr_one = c_caw'(1);
  localparam logic [c_raw-1:0] c_res_ptr_one = c_raw'(1);
  localparam logic [c_caw:0]   c_cmd_cnt_one = (c_caw+1)'(1);
  localparam logic [c_raw:0]   c_res_cnt_one = (c_raw+1)'(1);

  localparam logic [1:0] c_op_enq = 2'b01;
  localparam logic [1:0] c_op_deq = 2'b10;
  localparam logic [1:0] c_op_rep = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    kv_t        kv;
  } cmd_t;

  typedef struct packed {
    logic err;
    kv_t  kv;
  } res_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  cmd_t           r_cmd_mem [CMD_DEPTH];
  logic [c_caw-1:0] r_cmd_wr;
  logic [c_caw-1:0] r_cmd_rd;
  logic [c_caw:0]   r_cmd_cnt;

  res_t           r_res_mem [RES_DEPTH];
  logic [c_raw-1:0] r_res_wr;
  logic [c_raw-1:0] r_res_rd;
  logic [c_raw:0]   r_res_cnt;

  logic [15:0]    r_drop_cnt;

  cmd_t           w_cmd_in;
  cmd_t           w_head;
  res_t           w_res_head;
  res_t           w_res_data;
  logic           w_cmd_full;
  logic           w_cmd_push;
  logic           w_res_space;
  logic           w_res_valid;
  logic           w_res_pop;
  logic           w_needs_res;
  logic           w_issue;
  logic           w_enq;
  logic           w_deq;
  logic           w_res_push;
  logic           w_drop;

  assign w_cmd_in    = {bus.s_op, bus.s_kv};
  assign w_head      = r_cmd_mem[r_cmd_rd];
  assign w_res_head  = r_res_mem[r_res_rd];
  assign w_cmd_full  = (r_cmd_cnt == c_cmd_full);
  assign w_cmd_push  = bus.s_valid && !w_cmd_full;
  assign w_res_space = (r_res_cnt != c_res_full);
  assign w_res_valid = (r_res_cnt != '0);
  assign w_res_pop   = w_res_valid && bus.m_ready;
  assign w_needs_res = (w_head.op == c_op_deq) || (w_head.op == c_op_rep);

  // Result space is judged without the same-cycle pop so an issue never races a full FIFO.
  assign w_issue = !rst && (r_state == ST_IDLE) && (r_cmd_cnt != '0) &&
                   !bus.pq_busy && (!w_needs_res || w_res_space);

  always_comb begin
    w_enq            = 1'b0;
    w_deq            = 1'b0;
    w_res_push       = 1'b0;
    w_drop           = 1'b0;
    w_res_data.err   = 1'b0;
    w_res_data.kv    = bus.pq_kvo;
    w_state_nxt      = r_state;

    if (w_issue) begin
      case (w_head.op)
        c_op_enq: begin
          if (bus.pq_full) w_drop = 1'b1;
          else             w_enq  = 1'b1;
        end
        c_op_deq, c_op_rep: begin
          w_res_push = 1'b1;
          w_enq      = (w_head.op == c_op_rep);
          if (bus.pq_empty) begin
            w_res_data.err    = 1'b1;
            w_res_data.kv.key = KEYINF;
            w_res_data.kv.val = VAL0;
          end else begin
            w_deq = 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (r_state)
      ST_IDLE: if (w_enq || w_deq) w_state_nxt = ST_WAIT;
      ST_WAIT: if (!bus.pq_busy)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_wr  <= '0;
      r_cmd_rd  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + c_cmd_ptr_one;
      if (w_issue)    r_cmd_rd <= r_cmd_rd + c_cmd_ptr_one;
      if (w_cmd_push && !w_issue)      r_cmd_cnt <= r_cmd_cnt + c_cmd_cnt_one;
      else if (!w_cmd_push && w_issue) r_cmd_cnt <= r_cmd_cnt - c_cmd_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wr] <= w_cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) r_res_wr <= r_res_wr + c_res_ptr_one;
      if (w_res_pop)  r_res_rd <= r_res_rd + c_res_ptr_one;
      if (w_res_push && !w_res_pop)      r_res_cnt <= r_res_cnt + c_res_cnt_one;
      else if (!w_res_push && w_res_pop) r_res_cnt <= r_res_cnt - c_res_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_res_push) r_res_mem[r_res_wr] <= w_res_data;
  end

  always_ff @(posedge clk) begin
    if (rst)                                r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != '1)    r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign bus.s_ready  = !w_cmd_full;
  assign bus.m_valid  = w_res_valid;
  assign bus.m_kv     = w_res_head.kv;
  assign bus.m_err    = w_res_valid && w_res_head.err;
  assign bus.pq_enq   = w_enq;
  assign bus.pq_deq   = w_deq;
  assign bus.pq_kvi   = w_head.kv;
  assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pq_stream_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pq_stream_adapter
// Bench with a queue-based priority queue and an in-order result reference.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pq_stream_adapter;
  import pq_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 4;
  localparam int PQ_CAP    = 6;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_REP = 2'b11;

  typedef struct {
    kv_t  kv;
    logic err;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold_busy = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_enq = 0;
  int   n_deq = 0;

  kv_t         pq_q[$];
  kv_t         mdl_q[$];
  exp_t        exp_q[$];
  kv_t         got_kv[$];
  logic        got_err[$];
  logic [15:0] exp_drop = 16'd0;

  pq_stream_adapter_if bus();

  pq_stream_adapter #(
    .CMD_DEPTH(CMD_DEPTH),
    .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ins_pos(input kv_t q[$], input kv_t kv);
    int p = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].key > kv.key) begin
        p = i;
        break;
      end
    end
    return p;
  endfunction

  // Reference: every accepted command acts on an abstract PQ in acceptance order.
  task automatic model_apply(input logic [1:0] op, input kv_t kv);
    exp_t e;
    e.acc = cyc;
    e.err = 1'b0;
    e.kv  = kv;
    case (op)
      OP_ENQ: begin
        if (mdl_q.size() == PQ_CAP) begin
          if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end else begin
          mdl_q.insert(ins_pos(mdl_q, kv), kv);
        end
      end
      OP_DEQ, OP_REP: begin
        if (mdl_q.size() == 0) begin
          e.err    = 1'b1;
          e.kv.key = KEYINF;
          e.kv.val = VAL0;
        end else begin
          e.kv = mdl_q.pop_front();
        end
        exp_q.push_back(e);
        if (op == OP_REP) mdl_q.insert(ins_pos(mdl_q, kv), kv);
      end
      default: ;
    endcase
  endtask

  // Priority-queue environment with random post-strobe busy time.
  initial begin
    int busy_cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pq_q.delete();
        busy_cnt = 0;
      end else begin
        if (bus.pq_deq && pq_q.size() > 0) void'(pq_q.pop_front());
        if (bus.pq_enq && pq_q.size() < PQ_CAP) pq_q.insert(ins_pos(pq_q, bus.pq_kvi), bus.pq_kvi);
        if (bus.pq_enq || bus.pq_deq) busy_cnt = $urandom_range(0, 2);
        else if (busy_cnt > 0)        busy_cnt--;
      end
      bus.pq_empty <= (pq_q.size() == 0);
      bus.pq_full  <= (pq_q.size() == PQ_CAP);
      if (pq_q.size() > 0) bus.pq_kvo <= pq_q[0];
      else begin
        bus.pq_kvo.key <= KEYINF;
        bus.pq_kvo.val <= VAL0;
      end
      bus.pq_busy <= hold_busy || (busy_cnt != 0);
    end
  end

  // Compare process: samples mid-cycle, the handshakes take effect at the next edge.
  initial begin
    logic prev_rst = 1'b0;
    logic was_hold = 1'b0;
    kv_t  held_kv;
    logic held_err = 1'b0;
    exp_t e;
    held_kv = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("no_strobe_in_rst", {30'd0, bus.pq_enq, bus.pq_deq}, 32'd0);
        mdl_q.delete();
        exp_q.delete();
        exp_drop = 16'd0;
        was_hold = 1'b0;
      end else begin
        if (prev_rst) begin
          check("reset_s_ready", bus.s_ready, 1);
          check("reset_m_valid", bus.m_valid, 0);
          check("reset_m_err", bus.m_err, 0);
          check("reset_drop_cnt", bus.drop_cnt, 0);
        end
        if (bus.pq_enq) n_enq++;
        if (bus.pq_deq) n_deq++;
        if (was_hold) begin
          check("hold_m_valid", bus.m_valid, 1);
          check("hold_result", {bus.m_err, bus.m_kv}, {held_err, held_kv});
        end
        if (bus.m_valid && bus.m_ready) begin
          got_kv.push_back(bus.m_kv);
          got_err.push_back(bus.m_err);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result_unexpected: got %0h with nothing expected", {bus.m_err, bus.m_kv});
          end else begin
            e = exp_q.pop_front();
            check("result", {bus.m_err, bus.m_kv}, {e.err, e.kv});
            check("result_latency_ge2", (cyc - e.acc) >= 2, 1);
          end
        end
        was_hold = bus.m_valid && !bus.m_ready;
        held_kv  = bus.m_kv;
        held_err = bus.m_err;
        if (bus.s_valid && bus.s_ready) model_apply(bus.s_op, bus.s_kv);
      end
      prev_rst = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] key, input logic [7:0] val);
    bit acc = 1'b0;
    bus.s_valid    = 1'b1;
    bus.s_op       = op;
    bus.s_kv.key   = key;
    bus.s_kv.val   = val;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = bus.s_ready;
      tick();
    end
    bus.s_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready got 0 for 500 cycles, required 1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (30) tick();
    check("drop_cnt_model", bus.drop_cnt, exp_drop);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_enq;
    int base_deq;
    int nop_acc;
    bit saw_full;
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_op     = OP_NOP;
    bus.s_kv     = '0;
    bus.m_ready  = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Ordered dequeue of 5, 2, 9.
    got_kv.delete(); got_err.delete();
    send(OP_ENQ, 8'd5, 8'h50);
    send(OP_ENQ, 8'd2, 8'h20);
    send(OP_ENQ, 8'd9, 8'h90);
    repeat (3) send(OP_DEQ, 8'd0, 8'd0);
    wait_idle();
    check("basic_count", got_kv.size(), 3);
    if (got_kv.size() == 3) begin
      check("basic_k0", {got_err[0], got_kv[0]}, {1'b0, 8'd2, 8'h20});
      check("basic_k1", {got_err[1], got_kv[1]}, {1'b0, 8'd5, 8'h50});
      check("basic_k2", {got_err[2], got_kv[2]}, {1'b0, 8'd9, 8'h90});
    end

    // Dequeue on empty queue.
    do_reset();
    got_kv.delete(); got_err.delete();
    base_deq = n_deq;
    send(OP_DEQ, 8'd0, 8'd0);
    wait_idle();
    check("empty_count", got_kv.size(), 1);
    if (got_kv.size() == 1) check("empty_result", {got_err[0], got_kv[0]}, {1'b1, 8'hFF, 8'h00});
    check("empty_no_deq_strobe", n_deq - base_deq, 0);

    // Drop on full, then saturation.
    do_reset();
    base_enq = n_enq;
    for (int k = 0; k < PQ_CAP; k++) send(OP_ENQ, 8'(10 + k), 8'(k));
    send(OP_ENQ, 8'd16, 8'h16);
    wait_idle();
    check("full_enq_strobes", n_enq - base_enq, PQ_CAP);
    check("full_drop_one", bus.drop_cnt, 16'd1);
    check("full_pq_min", bus.pq_kvo.key, 8'd10);
    for (int k = 0; k < 65536; k++) send(OP_ENQ, 8'd20, 8'h00);
    wait_idle();
    check("drop_saturated", bus.drop_cnt, 16'hFFFF);

    // Result back-pressure.
    do_reset();
    for (int k = 0; k < RES_DEPTH + 2; k++) send(OP_ENQ, 8'(40 + k), 8'(k));
    wait_idle();
    got_kv.delete(); got_err.delete();
    bus.m_ready = 1'b0;
    base_deq = n_deq;
    for (int k = 0; k < RES_DEPTH + 2; k++) send(OP_DEQ, 8'd0, 8'd0);
    nop_acc  = 0;
    saw_full = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_op    = OP_NOP;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.s_ready) nop_acc++;
      else             saw_full = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (20) tick();
    check("bp_deq_strobes", n_deq - base_deq, RES_DEPTH);
    check("bp_s_ready_dropped", saw_full, 1);
    check("bp_nops_accepted", nop_acc, CMD_DEPTH - 2);
    bus.m_ready = 1'b1;
    wait_idle();
    check("bp_count", got_kv.size(), RES_DEPTH + 2);
    for (int k = 0; k < RES_DEPTH + 2; k++)
      if (k < got_kv.size()) check("bp_order", got_kv[k].key, 40 + k);

    // Replace on non-empty and empty queue.
    do_reset();
    send(OP_ENQ, 8'd4, 8'h44);
    wait_idle();
    got_kv.delete(); got_err.delete();
    send(OP_REP, 8'd7, 8'h77);
    wait_idle();
    check("rep_count", got_kv.size(), 1);
    if (got_kv.size() == 1) check("rep_result", {got_err[0], got_kv[0]}, {1'b0, 8'd4, 8'h44});
    check("rep_pq_min", bus.pq_kvo, {8'd7, 8'h77});
    do_reset();
    got_kv.delete(); got_err.delete();
    send(OP_REP, 8'd6, 8'h66);
    wait_idle();
    check("rep_empty_count", got_kv.size(), 1);
    if (got_kv.size() == 1) check("rep_empty_result", {got_err[0], got_kv[0]}, {1'b1, 8'hFF, 8'h00});
    check("rep_empty_pq_min", bus.pq_kvo, {8'd6, 8'h66});

    // Reset with commands queued and results pending.
    do_reset();
    for (int k = 0; k < 3; k++) send(OP_ENQ, 8'(60 + k), 8'(k));
    wait_idle();
    bus.m_ready = 1'b0;
    send(OP_DEQ, 8'd0, 8'd0);
    send(OP_DEQ, 8'd0, 8'd0);
    repeat (10) tick();
    hold_busy = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) send(OP_ENQ, 8'(70 + k), 8'(k));
    check("mid_rst_pending", bus.m_valid, 1);
    base_enq = n_enq;
    base_deq = n_deq;
    rst = 1'b1;
    tick();
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_s_ready", bus.s_ready, 1);
    rst = 1'b0;
    hold_busy = 1'b0;
    bus.m_ready = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_strobes", (n_enq - base_enq) + (n_deq - base_deq), 0);

    // Randomised traffic with one reset in the middle.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        bus.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      bus.s_valid    = ($urandom_range(0, 9) < 6);
      bus.s_op       = 2'($urandom_range(0, 3));
      bus.s_kv.key   = 8'($urandom_range(0, 254));
      bus.s_kv.val   = 8'($urandom);
      bus.m_ready    = ($urandom_range(0, 9) < 7);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
